// File: rtl/mm_drain_pkg.sv
// Shared types and elaboration helpers for the GEMM result drain.
package mm_drain_pkg;

    typedef enum logic {StIdle, StDrain} state_e;

    function automatic int unsigned res_width(input int unsigned data_width);
        return 4 * data_width;
    endfunction

    function automatic int unsigned beat_count(input int unsigned rows, input int unsigned cols,
                                               input int unsigned lanes);
        return (rows * cols) / lanes;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_res_beat_sel.sv
// Combinational lane selector: picks LANES consecutive elements for a beat.
// Optional ReLU on the emitted lanes when MM_RES_DRAIN_RELU_EN is defined.
module mm_res_beat_sel
    import mm_drain_pkg::*;
#(
    parameter int unsigned RES_WIDTH = 32,
    parameter int unsigned ELEMS     = 64,
    parameter int unsigned LANES     = 1,
    parameter int unsigned BEAT_W    = 6
) (
    input  logic [RES_WIDTH*ELEMS-1:0] buf_i,
    input  logic [BEAT_W-1:0]          beat_i,
    output logic [RES_WIDTH*LANES-1:0] data_o
);

    logic [RES_WIDTH-1:0] elem;

    always_comb begin
        data_o = '0;
        elem   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            elem = buf_i[(32'(beat_i) * LANES + l) * RES_WIDTH +: RES_WIDTH];
`ifdef MM_RES_DRAIN_RELU_EN
            if (elem[RES_WIDTH-1]) begin
                elem = '0;
            end
`endif
            data_o[l*RES_WIDTH +: RES_WIDTH] = elem;
        end
    end

endmodule

// File: rtl/mm_res_drain.sv
// Result drain: captures a full result matrix and streams it out LANES elements per beat.
// Optional output ReLU via MM_RES_DRAIN_RELU_EN (see mm_res_beat_sel).
module mm_res_drain
    import mm_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROW_NUM    = 8,
    parameter int unsigned COL_NUM    = 8,
    parameter int unsigned LANES      = 1,
    localparam int unsigned RES_WIDTH = res_width(DATA_WIDTH),
    localparam int unsigned ELEMS     = ROW_NUM * COL_NUM,
    localparam int unsigned ROW_W     = idx_width(ROW_NUM),
    localparam int unsigned COL_W     = idx_width(COL_NUM)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [RES_WIDTH*ELEMS-1:0] res_in_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [RES_WIDTH*LANES-1:0] out_data_o,
    output logic [ROW_W-1:0]           out_row_o,
    output logic [COL_W-1:0]           out_col_o,
    output logic                       out_last_o
);

    localparam int unsigned BEATS  = beat_count(ROW_NUM, COL_NUM, LANES);
    localparam int unsigned BEAT_W = idx_width(BEATS);
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS - 1);

    if (COL_NUM % LANES != 0) begin : g_lanes_check
        $error("mm_res_drain: LANES must divide COL_NUM");
    end

    state_e                     state_q, state_d;
    logic [BEAT_W-1:0]          beat_q, beat_d;
    logic [RES_WIDTH*ELEMS-1:0] buf_q, buf_d;
    logic [RES_WIDTH*LANES-1:0] sel_data;
    logic                       is_last;
    int unsigned                elem_idx;

    mm_res_beat_sel #(
        .RES_WIDTH (RES_WIDTH),
        .ELEMS     (ELEMS),
        .LANES     (LANES),
        .BEAT_W    (BEAT_W)
    ) u_beat_sel (
        .buf_i  (buf_q),
        .beat_i (beat_q),
        .data_o (sel_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            beat_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    buf_d   = res_in_i;
                    beat_d  = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_ready_i) begin
                    if (beat_q != LastBeat) begin
                        beat_d = beat_q + 1'b1;
                    end else if (in_valid_i) begin
                        // Back-to-back: reload on the last handshake, no bubble.
                        buf_d  = res_in_i;
                        beat_d = '0;
                    end else begin
                        beat_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        is_last     = (beat_q == LastBeat);
        elem_idx    = 32'(beat_q) * LANES;
        out_valid_o = (state_q == StDrain);
        out_last_o  = (state_q == StDrain) && is_last;
        out_data_o  = (state_q == StDrain) ? sel_data : '0;
        out_row_o   = (state_q == StDrain) ? ROW_W'(elem_idx / COL_NUM) : '0;
        out_col_o   = (state_q == StDrain) ? COL_W'(elem_idx % COL_NUM) : '0;
        in_ready_o  = (state_q == StIdle) || (is_last && out_ready_i);
    end

endmodule

// File: tb/tb_mm_res_drain.sv
// Directed bench for mm_res_drain: 2x2 matrix with LANES=1 and LANES=2 instances.
module tb_mm_res_drain;

    logic         clk;
    logic         rst_n;
    logic [127:0] res_in;
    logic         in_valid_a, out_ready_a, in_ready_a, out_valid_a, out_last_a;
    logic [31:0]  out_data_a;
    logic [0:0]   out_row_a, out_col_a;
    logic         in_valid_b, out_ready_b, in_ready_b, out_valid_b, out_last_b;
    logic [63:0]  out_data_b;
    logic [0:0]   out_row_b, out_col_b;

    int vecs  = 0;
    int fails = 0;

    localparam logic [127:0] M1 = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] M2 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    localparam logic [127:0] M3 = {32'h44, 32'h33, 32'hFFFF_FFF6, 32'h11};

    mm_res_drain #(
        .DATA_WIDTH (8),
        .ROW_NUM    (2),
        .COL_NUM    (2),
        .LANES      (1)
    ) dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid_a),
        .in_ready_o  (in_ready_a),
        .res_in_i    (res_in),
        .out_valid_o (out_valid_a),
        .out_ready_i (out_ready_a),
        .out_data_o  (out_data_a),
        .out_row_o   (out_row_a),
        .out_col_o   (out_col_a),
        .out_last_o  (out_last_a)
    );

    mm_res_drain #(
        .DATA_WIDTH (8),
        .ROW_NUM    (2),
        .COL_NUM    (2),
        .LANES      (2)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid_b),
        .in_ready_o  (in_ready_b),
        .res_in_i    (res_in),
        .out_valid_o (out_valid_b),
        .out_ready_i (out_ready_b),
        .out_data_o  (out_data_b),
        .out_row_o   (out_row_b),
        .out_col_o   (out_col_b),
        .out_last_o  (out_last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat_a(input string tag, input logic [31:0] d, input logic r, input logic c,
                          input logic l);
        chk({tag, ".valid"}, 128'(out_valid_a), 128'(1'b1));
        chk({tag, ".data"}, 128'(out_data_a), 128'(d));
        chk({tag, ".row"}, 128'(out_row_a), 128'(r));
        chk({tag, ".col"}, 128'(out_col_a), 128'(c));
        chk({tag, ".last"}, 128'(out_last_a), 128'(l));
    endtask

    task automatic idle_a(input string tag);
        chk({tag, ".valid"}, 128'(out_valid_a), 128'(1'b0));
        chk({tag, ".in_ready"}, 128'(in_ready_a), 128'(1'b1));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        res_in      = '0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b0;
        tick();
        tick();
        // Reset state
        idle_a("rst_a");
        chk("rst_a.data", 128'(out_data_a), 128'd0);
        chk("rst_a.last", 128'(out_last_a), 128'd0);
        chk("rst_b.valid", 128'(out_valid_b), 128'd0);
        chk("rst_b.in_ready", 128'(in_ready_b), 128'd1);
        rst_n = 1'b1;

        // Basic drain
        tick();
        in_valid_a  = 1'b1;
        res_in      = M1;
        out_ready_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        beat_a("basic0", 32'h11, 1'b0, 1'b0, 1'b0);
        chk("basic0.in_ready", 128'(in_ready_a), 128'd0);
        tick();
        beat_a("basic1", 32'h22, 1'b0, 1'b1, 1'b0);
        tick();
        beat_a("basic2", 32'h33, 1'b1, 1'b0, 1'b0);
        tick();
        beat_a("basic3", 32'h44, 1'b1, 1'b1, 1'b1);
        chk("basic3.in_ready", 128'(in_ready_a), 128'd1);
        tick();
        idle_a("basic_end");

        // Backpressure on beat 1
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        beat_a("bp0", 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready_a = 1'b0;
        beat_a("bp1_s0", 32'h22, 1'b0, 1'b1, 1'b0);
        chk("bp1_s0.in_ready", 128'(in_ready_a), 128'd0);
        tick();
        beat_a("bp1_s1", 32'h22, 1'b0, 1'b1, 1'b0);
        tick();
        beat_a("bp1_s2", 32'h22, 1'b0, 1'b1, 1'b0);
        out_ready_a = 1'b1;
        tick();
        beat_a("bp2", 32'h33, 1'b1, 1'b0, 1'b0);
        tick();
        beat_a("bp3", 32'h44, 1'b1, 1'b1, 1'b1);
        tick();
        idle_a("bp_end");

        // Back-to-back matrices
        in_valid_a = 1'b1;
        res_in     = M1;
        tick();
        res_in = M2;
        beat_a("b2b0", 32'h11, 1'b0, 1'b0, 1'b0);
        chk("b2b0.in_ready", 128'(in_ready_a), 128'd0);
        tick();
        beat_a("b2b1", 32'h22, 1'b0, 1'b1, 1'b0);
        tick();
        beat_a("b2b2", 32'h33, 1'b1, 1'b0, 1'b0);
        tick();
        beat_a("b2b3", 32'h44, 1'b1, 1'b1, 1'b1);
        chk("b2b3.in_ready", 128'(in_ready_a), 128'd1);
        tick();
        in_valid_a = 1'b0;
        beat_a("b2b4", 32'hA0, 1'b0, 1'b0, 1'b0);
        tick();
        beat_a("b2b5", 32'hA1, 1'b0, 1'b1, 1'b0);
        tick();
        beat_a("b2b6", 32'hA2, 1'b1, 1'b0, 1'b0);
        tick();
        beat_a("b2b7", 32'hA3, 1'b1, 1'b1, 1'b1);
        tick();
        idle_a("b2b_end");

        // Reset mid-drain
        in_valid_a = 1'b1;
        res_in     = M1;
        tick();
        in_valid_a = 1'b0;
        tick();
        beat_a("mid1", 32'h22, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        idle_a("mid_rst");
        chk("mid_rst.data", 128'(out_data_a), 128'd0);
        chk("mid_rst.row", 128'(out_row_a), 128'd0);
        chk("mid_rst.col", 128'(out_col_a), 128'd0);
        chk("mid_rst.last", 128'(out_last_a), 128'd0);
        tick();
        idle_a("mid_rst_hold");
        rst_n      = 1'b1;
        in_valid_a = 1'b1;
        res_in     = M2;
        tick();
        in_valid_a = 1'b0;
        beat_a("post0", 32'hA0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        beat_a("post3", 32'hA3, 1'b1, 1'b1, 1'b1);
        tick();
        idle_a("post_end");

        // LANES=2
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        res_in      = M1;
        tick();
        in_valid_b = 1'b0;
        chk("l2b0.valid", 128'(out_valid_b), 128'd1);
        chk("l2b0.data", 128'(out_data_b), 128'h0000_0022_0000_0011);
        chk("l2b0.row", 128'(out_row_b), 128'd0);
        chk("l2b0.col", 128'(out_col_b), 128'd0);
        chk("l2b0.last", 128'(out_last_b), 128'd0);
        tick();
        chk("l2b1.data", 128'(out_data_b), 128'h0000_0044_0000_0033);
        chk("l2b1.row", 128'(out_row_b), 128'd1);
        chk("l2b1.col", 128'(out_col_b), 128'd0);
        chk("l2b1.last", 128'(out_last_b), 128'd1);
        tick();
        chk("l2_end.valid", 128'(out_valid_b), 128'd0);

        // Negative element: ReLU'd only when the feature is built in
        in_valid_a = 1'b1;
        res_in     = M3;
        tick();
        in_valid_a = 1'b0;
        beat_a("neg0", 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef MM_RES_DRAIN_RELU_EN
        beat_a("neg1", 32'h0, 1'b0, 1'b1, 1'b0);
`else
        beat_a("neg1", 32'hFFFF_FFF6, 1'b0, 1'b1, 1'b0);
`endif
        tick();
        beat_a("neg2", 32'h33, 1'b1, 1'b0, 1'b0);
        tick();
        beat_a("neg3", 32'h44, 1'b1, 1'b1, 1'b1);
        tick();
        idle_a("neg_end");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
